// File: rtl/emu_ckpt_pkg.sv
// Shared definitions for the checkpoint scan-out writer: state encoding and
// the word-counter width helper.
package emu_ckpt_pkg;

    typedef logic [2:0] ckpt_state_t;

    localparam ckpt_state_t ST_IDLE  = 3'd0;
    localparam ckpt_state_t ST_HALT  = 3'd1;
    localparam ckpt_state_t ST_HDR   = 3'd2;
    localparam ckpt_state_t ST_FF    = 3'd3;
    localparam ckpt_state_t ST_MEM   = 3'd4;
    localparam ckpt_state_t ST_DRAIN = 3'd5;

    // Counter must hold the larger chain length in words.
    function automatic int cnt_width(input int ff_words, input int mem_words);
        int longest;
        longest = (ff_words > mem_words) ? ff_words : mem_words;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/emu_ckpt_skid.sv
// Two-entry valid/ready skid buffer; the output register holds the word on
// the stream and the skid register catches one word while the sink stalls.
module emu_ckpt_skid #(
    parameter int W = 65
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         empty
);

    logic         skid_valid;
    logic [W-1:0] skid_data;
    logic         in_fire;
    logic         out_open;

    // Accept only while the skid slot is free, so a full buffer stops upstream.
    assign in_ready = ~skid_valid;
    assign in_fire  = in_valid & in_ready;
    assign out_open = ~out_valid | out_ready;
    assign empty    = ~out_valid & ~skid_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (out_open) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= in_fire;
                if (in_fire) begin
                    out_data <= in_data;
                end
            end
        end else if (in_fire) begin
            // Output word is stalled: hold it and park the new word.
            skid_valid <= 1'b1;
            skid_data  <= in_data;
        end
    end

endmodule

// File: rtl/emu_ckpt_scanout.sv
// Checkpoint writer: halts the emulated clock, rotates the FF then memory scan
// chains and streams each word out. Optional header word: EMU_CKPT_HEADER_EN.
module emu_ckpt_scanout
    import emu_ckpt_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int FF_WORDS   = 16,
    parameter int MEM_WORDS  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  halt_req,
    input  logic                  halted,
    input  logic                  emu_clk_en,
    output logic                  ff_se,
    input  logic [DATA_WIDTH-1:0] ff_so,
    output logic [DATA_WIDTH-1:0] ff_si,
    output logic                  mem_se,
    input  logic [DATA_WIDTH-1:0] mem_so,
    output logic [DATA_WIDTH-1:0] mem_si,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  dout_last,
    output logic [2:0]            dbg_state
);

    localparam int CW = cnt_width(FF_WORDS, MEM_WORDS);

    ckpt_state_t           state;
    ckpt_state_t           state_nxt;
    logic [CW-1:0]         cnt;
    logic                  ff_final;
    logic                  mem_final;
    logic                  skid_in_valid;
    logic                  skid_in_ready;
    logic                  skid_empty;
    logic                  push;
    logic                  push_last;
    logic [DATA_WIDTH-1:0] push_data;
    logic [DATA_WIDTH:0]   skid_out;

`ifdef EMU_CKPT_HEADER_EN
    logic [63:0]           emu_cyc;
    logic [DATA_WIDTH-1:0] hdr_word;

    // Free-running emulated-cycle count; survives captures, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            emu_cyc <= '0;
        end else if (emu_clk_en) begin
            emu_cyc <= emu_cyc + 64'd1;
        end
    end

    assign hdr_word = DATA_WIDTH'(emu_cyc);
`else
    logic unused_emu_clk_en;
    assign unused_emu_clk_en = emu_clk_en;
`endif

    assign ff_final  = (cnt == CW'(FF_WORDS - 1));
    assign mem_final = (cnt == CW'(MEM_WORDS - 1));

    always_comb begin
        state_nxt     = state;
        skid_in_valid = 1'b0;
        push_data     = '0;
        push_last     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                if (halted) begin
`ifdef EMU_CKPT_HEADER_EN
                    state_nxt = ST_HDR;
`else
                    state_nxt = ST_FF;
`endif
                end
            end
`ifdef EMU_CKPT_HEADER_EN
            ST_HDR: begin
                skid_in_valid = 1'b1;
                push_data     = hdr_word;
                if (skid_in_ready) begin
                    state_nxt = ST_FF;
                end
            end
`endif
            ST_FF: begin
                skid_in_valid = 1'b1;
                push_data     = ff_so;
                push_last     = (MEM_WORDS == 0) && ff_final;
                if (skid_in_ready && ff_final) begin
                    state_nxt = (MEM_WORDS == 0) ? ST_DRAIN : ST_MEM;
                end
            end
            ST_MEM: begin
                skid_in_valid = 1'b1;
                push_data     = mem_so;
                push_last     = mem_final;
                if (skid_in_ready && mem_final) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (skid_empty) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Any state change enters a new phase, so the word count restarts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (push) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign push = skid_in_valid & skid_in_ready;

    // A chain shifts exactly when its head word is taken by the buffer.
    assign ff_se  = (state == ST_FF) & skid_in_ready;
    assign mem_se = (state == ST_MEM) & skid_in_ready;
    assign ff_si  = ff_so;
    assign mem_si = mem_so;

    assign busy      = (state != ST_IDLE);
    assign halt_req  = (state != ST_IDLE);
    assign done      = (state == ST_DRAIN) & skid_empty;
    assign dbg_state = state;

    emu_ckpt_skid #(
        .W(DATA_WIDTH + 1)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (skid_in_valid),
        .in_ready (skid_in_ready),
        .in_data  ({push_last, push_data}),
        .out_valid(dout_valid),
        .out_ready(dout_ready),
        .out_data (skid_out),
        .empty    (skid_empty)
    );

    assign dout_last = skid_out[DATA_WIDTH];
    assign dout_data = skid_out[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_emu_ckpt_scanout.sv
// Bench for emu_ckpt_scanout: a 4+2 word instance driven from a vector table
// plus reset-abort sequence, and a 3+0 word instance for the no-memory case.
module tb_emu_ckpt_scanout;
  import emu_ckpt_pkg::*;

  localparam int DW = 64;
`ifdef EMU_CKPT_HEADER_EN
  localparam int HDR_W = 1;
`else
  localparam int HDR_W = 0;
`endif

  typedef logic [DW:0] word_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int errors = 0;
  int checks = 0;

  // ---------------- instance A: FF=4, MEM=2 ----------------
  logic start_a = 1'b0, halted_a = 1'b0, emu_clk_en_a = 1'b0, ready_a = 1'b1;
  logic busy_a, done_a, halt_req_a, ff_se_a, mem_se_a, dout_valid_a, dout_last_a;
  logic [DW-1:0] ff_so_a, ff_si_a, mem_so_a, mem_si_a, dout_data_a;
  logic [2:0] state_a;

  emu_ckpt_scanout #(.DATA_WIDTH(DW), .FF_WORDS(4), .MEM_WORDS(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
    .halt_req(halt_req_a), .halted(halted_a), .emu_clk_en(emu_clk_en_a),
    .ff_se(ff_se_a), .ff_so(ff_so_a), .ff_si(ff_si_a),
    .mem_se(mem_se_a), .mem_so(mem_so_a), .mem_si(mem_si_a),
    .dout_valid(dout_valid_a), .dout_ready(ready_a), .dout_data(dout_data_a),
    .dout_last(dout_last_a), .dbg_state(state_a)
  );

  logic [DW-1:0] ff_ch_a[4];
  logic [DW-1:0] mem_ch_a[2];
  logic load_a = 1'b0;
  logic [DW-1:0] base_a = '0;
  logic [63:0] emu_cnt_a = '0;

  // Scan chain model: head word out, loopback word shifted in at the tail.
  always @(posedge clk) begin
    if (load_a) begin
      for (int i = 0; i < 4; i++) ff_ch_a[i] <= base_a + DW'(i);
      for (int i = 0; i < 2; i++) mem_ch_a[i] <= base_a + DW'(4 + i);
    end else begin
      if (ff_se_a) begin
        for (int i = 0; i < 3; i++) ff_ch_a[i] <= ff_ch_a[i+1];
        ff_ch_a[3] <= ff_si_a;
      end
      if (mem_se_a) begin
        mem_ch_a[0] <= mem_ch_a[1];
        mem_ch_a[1] <= mem_si_a;
      end
    end
  end
  assign ff_so_a  = ff_ch_a[0];
  assign mem_so_a = mem_ch_a[0];

  // ---------------- instance B: FF=3, MEM=0 ----------------
  logic start_b = 1'b0, halted_b = 1'b0, emu_clk_en_b = 1'b0, ready_b = 1'b1;
  logic busy_b, done_b, halt_req_b, ff_se_b, mem_se_b, dout_valid_b, dout_last_b;
  logic [DW-1:0] ff_so_b, ff_si_b, mem_si_b, dout_data_b;
  logic [DW-1:0] mem_so_b = '0;
  logic [2:0] state_b;

  emu_ckpt_scanout #(.DATA_WIDTH(DW), .FF_WORDS(3), .MEM_WORDS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
    .halt_req(halt_req_b), .halted(halted_b), .emu_clk_en(emu_clk_en_b),
    .ff_se(ff_se_b), .ff_so(ff_so_b), .ff_si(ff_si_b),
    .mem_se(mem_se_b), .mem_so(mem_so_b), .mem_si(mem_si_b),
    .dout_valid(dout_valid_b), .dout_ready(ready_b), .dout_data(dout_data_b),
    .dout_last(dout_last_b), .dbg_state(state_b)
  );

  logic [DW-1:0] ff_ch_b[3];
  logic load_b = 1'b0;

  always @(posedge clk) begin
    if (load_b) begin
      for (int i = 0; i < 3; i++) ff_ch_b[i] <= 64'h20 + DW'(i);
    end else if (ff_se_b) begin
      ff_ch_b[0] <= ff_ch_b[1];
      ff_ch_b[1] <= ff_ch_b[2];
      ff_ch_b[2] <= ff_si_b;
    end
  end
  assign ff_so_b = ff_ch_b[0];

  // ---------------- scoreboard ----------------
  word_t exp_q[$];
  word_t exp_q_b[$];

  task automatic check(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  int done_cnt_a = 0, done_cyc_a = 0, ff_shift_a = 0, occ_a = 0;
  int done_cnt_b = 0;
  bit prev_stall_a = 1'b0;
  word_t prev_word_a = '0;

  always @(negedge clk) begin
    word_t got;
    got = {dout_last_a, dout_data_a};
    if (prev_stall_a) begin
      check("stall_hold_valid_a", word_t'(dout_valid_a), word_t'(1));
      check("stall_hold_data_a", got, prev_word_a);
    end
    if (dout_valid_a && ready_a) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word_a: got %h expected none", got);
      end else begin
        check("word_a", got, exp_q.pop_front());
      end
    end
    if (ff_se_a || mem_se_a) begin
      check("se_exclusive_a", word_t'(ff_se_a && mem_se_a), '0);
      check("se_before_halted_a", word_t'(!halted_a), '0);
`ifndef EMU_CKPT_HEADER_EN
      check("se_while_full_a", word_t'(occ_a >= 2), '0);
`endif
    end
    occ_a = occ_a + int'(ff_se_a || mem_se_a) - int'(dout_valid_a && ready_a);
    if (ff_se_a) ff_shift_a++;
    if (done_a) begin
      done_cnt_a++;
      done_cyc_a = cyc_cnt;
    end
    prev_stall_a = dout_valid_a && !ready_a;
    prev_word_a = got;
    if (!rst_n) begin
      occ_a = 0;
      prev_stall_a = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (dout_valid_b && ready_b) begin
      if (exp_q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word_b: got %h expected none", {dout_last_b, dout_data_b});
      end else begin
        check("word_b", {dout_last_b, dout_data_b}, exp_q_b.pop_front());
      end
    end
    if (busy_b) check("mem_se_never_b", word_t'(mem_se_b), '0);
    if (done_b) done_cnt_b++;
  end

  // Chains must stay frozen with the emulated clock gated.
  always @(negedge clk) begin
    if (rst_n && (state_a == ST_FF || state_a == ST_MEM || state_a == ST_DRAIN))
      assert (halted_a) else $error("halted dropped during capture");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_chain_a(input logic [DW-1:0] base);
    base_a = base;
    load_a = 1'b1;
    tick();
    load_a = 1'b0;
  endtask

  task automatic push_expected_a();
`ifdef EMU_CKPT_HEADER_EN
    exp_q.push_back({1'b0, emu_cnt_a});
`endif
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, ff_ch_a[i]});
    for (int i = 0; i < 2; i++) exp_q.push_back({i == 1, mem_ch_a[i]});
  endtask

  task automatic run_capture_a(input int rmode, input int hdelay, input bit repulse,
                               input int exp_lat);
    logic [DW-1:0] ff_orig[4];
    logic [DW-1:0] mem_orig[2];
    int d0, t0;
    bit finished;
    ff_orig = ff_ch_a;
    mem_orig = mem_ch_a;
    push_expected_a();
    d0 = done_cnt_a;
    start_a = 1'b1;
    t0 = cyc_cnt;
    tick();
    start_a = 1'b0;
    check("halt_req_after_start", word_t'(halt_req_a), word_t'(1));
    check("busy_after_start", word_t'(busy_a), word_t'(1));
    finished = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (done_cnt_a != d0) begin
        finished = 1'b1;
        break;
      end
      halted_a = (c >= hdelay);
      case (rmode)
        0: ready_a = 1'b1;
        1: ready_a = ((c % 4) == 0) || ((c % 4) == 3);
        default: ready_a = 1'($urandom_range(0, 1));
      endcase
      start_a = repulse && ((c % 5) == 2);
      tick();
    end
    start_a = 1'b0;
    ready_a = 1'b1;
    halted_a = 1'b0;
    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL timeout_a: got no done expected done within 600 cycles");
    end else if (exp_lat > 0) begin
      check("done_latency_a", word_t'(done_cyc_a - t0), word_t'(exp_lat + HDR_W));
    end
    repeat (3) tick();
    check("done_once_a", word_t'(done_cnt_a - d0), word_t'(1));
    check("queue_empty_a", word_t'(exp_q.size()), '0);
    for (int i = 0; i < 4; i++) check("ff_restored_a", {1'b0, ff_ch_a[i]}, {1'b0, ff_orig[i]});
    for (int i = 0; i < 2; i++) check("mem_restored_a", {1'b0, mem_ch_a[i]}, {1'b0, mem_orig[i]});
    check("idle_busy_a", word_t'(busy_a), '0);
    check("idle_halt_req_a", word_t'(halt_req_a), '0);
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_busy"}, word_t'(busy_a), '0);
    check({tag, "_done"}, word_t'(done_a), '0);
    check({tag, "_halt_req"}, word_t'(halt_req_a), '0);
    check({tag, "_ff_se"}, word_t'(ff_se_a), '0);
    check({tag, "_mem_se"}, word_t'(mem_se_a), '0);
    check({tag, "_dout_valid"}, word_t'(dout_valid_a), '0);
    check({tag, "_dout_last"}, word_t'(dout_last_a), '0);
    check({tag, "_dout_data"}, {1'b0, dout_data_a}, '0);
    check({tag, "_state"}, word_t'(state_a), word_t'(ST_IDLE));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [DW-1:0] base;
    int rmode;
    int hdelay;
    bit repulse;
    int exp_lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int d0, s0, db0;
    bit reached;

    vecs[0] = '{64'h10, 0, 1, 1'b0, 10};
    vecs[1] = '{64'h10, 1, 1, 1'b0, 0};
    vecs[2] = '{{$urandom, $urandom}, 2, 0, 1'b0, 0};
    vecs[3] = '{64'h100, 0, 10, 1'b1, 19};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFF0, 0, 0, 1'b0, 9};

    repeat (3) tick();
    check_reset_a("reset");
    check("reset_busy_b", word_t'(busy_b), '0);
    rst_n = 1'b1;
    tick();

    // Emulated cycles before the first capture set the header value.
    for (int i = 0; i < 1000; i++) begin
      emu_clk_en_a = 1'b1;
      tick();
      emu_cnt_a++;
    end
    emu_clk_en_a = 1'b0;

    // No-memory instance: three FF words, last flag on the third.
    load_b = 1'b1;
    tick();
    load_b = 1'b0;
`ifdef EMU_CKPT_HEADER_EN
    exp_q_b.push_back('0);
`endif
    for (int i = 0; i < 3; i++) exp_q_b.push_back({i == 2, ff_ch_b[i]});
    db0 = done_cnt_b;
    halted_b = 1'b1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    reached = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (done_cnt_b != db0) begin
        reached = 1'b1;
        break;
      end
      tick();
    end
    halted_b = 1'b0;
    if (!reached) begin
      checks++;
      errors++;
      $display("FAIL timeout_b: got no done expected done within 100 cycles");
    end
    repeat (3) tick();
    check("done_once_b", word_t'(done_cnt_b - db0), word_t'(1));
    check("queue_empty_b", word_t'(exp_q_b.size()), '0);
    for (int i = 0; i < 3; i++) check("ff_restored_b", {1'b0, ff_ch_b[i]}, {1'b0, 64'h20 + DW'(i)});

    for (int v = 0; v < 5; v++) begin
      load_chain_a(vecs[v].base);
      run_capture_a(vecs[v].rmode, vecs[v].hdelay, vecs[v].repulse, vecs[v].exp_lat);
    end

    // Reset after the second FF word aborts the capture without done.
    load_chain_a(64'h200);
    push_expected_a();
    d0 = done_cnt_a;
    s0 = ff_shift_a;
    halted_a = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    reached = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (ff_shift_a - s0 >= 2) begin
        reached = 1'b1;
        break;
      end
      tick();
    end
    if (!reached) begin
      checks++;
      errors++;
      $display("FAIL timeout_shift_a: got %0d shifts expected 2", ff_shift_a - s0);
    end
    rst_n = 1'b0;
    tick();
    check_reset_a("abort");
    rst_n = 1'b1;
    halted_a = 1'b0;
    exp_q.delete();
    emu_cnt_a = '0;
    repeat (3) tick();
    check("abort_no_done", word_t'(done_cnt_a - d0), '0);

    // Fresh capture of the partially rotated chain.
    run_capture_a(0, 0, 1'b0, 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/emu_ckpt_scanout.md
# emu_ckpt_scanout

Hardware checkpoint writer for the emulator. On command it halts the emulated clock, rotates the FF scan chain and then the memory scan chain one word per cycle, and streams every word to the host through a valid/ready port in exactly the word order and width the checkpoint loader consumes: FF words first, then memory words. The chains are looped back during rotation, so design state is intact after capture. It sits between `emu_top`'s scan ports and the host DMA/buffer path.

## Interface
- `DATA_WIDTH`, 64, scan word width; equals the loader word width.
- `FF_WORDS`, 16, FF chain length in words; must be ≥1.
- `MEM_WORDS`, 8, memory chain length in words; 0 is legal.
- `clk` in 1: single clock. Emulated-clock gating is handled through `halt_req`.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle checkpoint request; accepted only in IDLE.
- `busy` out 1: high from accept until the `done` cycle, inclusive.
- `done` out 1: one-cycle pulse when capture completes.
- `halt_req` out 1: request to gate the emulated clock.
- `halted` in 1: emulated clock is gated.
- `emu_clk_en` in 1: emulated clock fired this cycle; used by the header feature.
- `ff_se` out 1: FF chain shift enable; shifts one word per cycle while high.
- `ff_so` in DATA_WIDTH: FF chain head word.
- `ff_si` out DATA_WIDTH: FF chain tail input; always driven with `ff_so` (loopback).
- `mem_se`, `mem_so`, `mem_si`: the same three signals for the memory chain.
- `dout_valid` out 1, `dout_ready` in 1, `dout_data` out DATA_WIDTH, `dout_last` out 1: output stream.

## Operation
- States: IDLE → HALT → (HDR) → FF → MEM → DRAIN → IDLE.
- IDLE:
  - `start` moves to HALT.
  - `start` in any other state is ignored; no queuing.
- HALT: `halt_req`=1. When `halted`=1, go to HDR if the header is compiled in, else FF.
- Word counter:
  - Width is $clog2(max(FF_WORDS, MEM_WORDS)+1).
  - Clears on each chain entry.
  - Increments on each pushed word.
- FF: each cycle the skid buffer can accept, `ff_se`=1 and `ff_so` is pushed. After FF_WORDS pushes, go to MEM, or to DRAIN if MEM_WORDS=0.
- MEM: same as FF using `mem_se`/`mem_so`, for MEM_WORDS pushes, then DRAIN.
- `ff_se` and `mem_se` are never high together. They are never high outside their own state.
- `dout_last`=1 only on the final word of the checkpoint: the final memory word, or the final FF word if MEM_WORDS=0.
- DRAIN:
  - Waits until the skid buffer is empty.
  - Then drops `halt_req`, pulses `done`, and returns to IDLE.
- Stall: with `dout_ready`=0, no shift occurs once the buffer is full, so no chain word is ever lost or duplicated.
- `halted` dropping before DRAIN completes is a protocol violation; behaviour is undefined, and bench assertions flag it.

## Timing
- Reset values: `busy`=0, `done`=0, `halt_req`=0, `ff_se`=0, `mem_se`=0, `dout_valid`=0, `dout_last`=0, `dout_data`=0, state=IDLE, skid buffer empty.
- Reset mid-capture:
  - Aborts immediately to the reset values above.
  - The chain is left partially rotated and is not restored.
  - `done` is not pulsed.
- `start` at cycle t: `halt_req`=1 and `busy`=1 at t+1.
- `halted` seen at cycle h: first shift (or header push) at h+1.
- Push-to-`dout_valid` latency is 1 cycle (registered output).
- Throughput: 1 word/cycle with `dout_ready` held high.
- Total for FF_WORDS=16, MEM_WORDS=8, `halted` immediate, ready always high: 24 shift cycles. The last word is on `dout` one cycle after the last shift; `done` follows one cycle after that word is accepted.
- Stream rule: `dout_data`/`dout_last` are held stable while `dout_valid`=1 and `dout_ready`=0.

## Configuration
- Macro: `EMU_CKPT_HEADER_EN`.
- Defined:
  - A 64-bit emulated-cycle counter increments on `emu_clk_en`. It is reset only by `rst_n`.
  - Its low DATA_WIDTH bits are emitted as one header word before the FF words.
  - The host uses this value as the start-cycle argument.
- Undefined:
  - No counter and no HDR state.
  - The stream is exactly FF_WORDS+MEM_WORDS words.

## Structure
- Shared package `emu_ckpt_pkg` holds:
  - the state enum (IDLE, HALT, HDR, FF, MEM, DRAIN);
  - the counter-width function.
- Sub-module `emu_ckpt_skid`: a 2-entry valid/ready skid buffer carrying {last, data}.
  - Its `in_ready` gates `ff_se`/`mem_se`.
  - Its output registers drive `dout_*`.

## Test plan
- FF=4, MEM=2, chain model preloaded 0x10..0x15, ready=1, `halted` one cycle after `halt_req` → `dout` carries 0x10..0x15, `dout_last` only on 0x15, `done` pulses once, and the chain model is back to its original contents.
- Same setup with `dout_ready` toggling 1,0,0,1 repeatedly → identical 6-word sequence, and no `ff_se`/`mem_se` while the buffer is full.
- MEM_WORDS=0, FF=3 → 3 words with `dout_last` on the third, and `mem_se` never high.
- `halted` delayed 10 cycles, with `start` re-pulsed during HALT and FF → no shift before `halted`, and exactly one capture.
- `rst_n`=0 after the 2nd FF word → all outputs return to reset values the next cycle, no `done`, and a fresh `start` produces a complete capture.
- `EMU_CKPT_HEADER_EN` defined, 1000 `emu_clk_en` pulses before `start` → first word 1000 (0x3E8), followed by FF+MEM words.
